// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator
// Integrates the corrected tuning word each enabled clock and emits truncated
// in-phase and quadrature (+90 degree) phase words for the sin/cos lookup.
// Tuning-word changes are either immediate or deferred to the next accumulator
// wrap (UPDATE_ON_WRAP) so that frequency hops stay phase continuous.
module nco_phase_accumulator #(
  parameter int ACC_W          = 32,
  parameter int OUT_W          = 12,
  parameter bit UPDATE_ON_WRAP = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [ACC_W-1:0] phaseIncCorr,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] phase_offset,
  input  logic             offset_load,
  input  logic             phase_clr,
  output logic [OUT_W-1:0] phaseI,
  output logic [OUT_W-1:0] phaseQ,
  output logic             phase_valid,
  output logic             wrap,
  output logic             inc_applied
);

  // Quarter turn expressed in output phase units: 2^(OUT_W-2).
  localparam logic [OUT_W-1:0] QUAD_STEP = {2'b01, {(OUT_W-2){1'b0}}};

  // Architectural state
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] incActive;
  logic [ACC_W-1:0] incPending;
  logic [ACC_W-1:0] offsetReg;
  logic             pendFlag;

  // Combinational datapath
  logic [ACC_W:0]   accSum;
  logic             accCarry;
  logic [ACC_W-1:0] offsetSum;
  logic [OUT_W-1:0] phaseINext;
  logic [OUT_W-1:0] phaseQNext;
  logic             advance;

  // Tuning-word control
  logic             wrapXfer;
  logic             deferLoads;
  logic [ACC_W-1:0] incActiveNext;
  logic [ACC_W-1:0] incPendingNext;
  logic             pendFlagNext;
  logic             incAppliedNext;

  // Accumulator sum with carry, offset phase and truncated I/Q phase words
  always_comb begin
    accSum     = {1'b0, acc} + {1'b0, incActive};
    accCarry   = accSum[ACC_W];
    offsetSum  = acc + offsetReg;
    phaseINext = OUT_W'(offsetSum >> (ACC_W - OUT_W));
    phaseQNext = phaseINext + QUAD_STEP;
    advance    = enable & ~phase_clr;
  end

  // Tuning-word selection: immediate load, or pending word handed over at wrap.
  // With a zero active word the accumulator is stationary and can never wrap,
  // so a load is applied directly; this is also how the very first word after
  // reset gets in when loads are deferred.
  always_comb begin
    incActiveNext  = incActive;
    incPendingNext = incPending;
    pendFlagNext   = pendFlag;
    incAppliedNext = 1'b0;
    deferLoads     = UPDATE_ON_WRAP && (incActive != {ACC_W{1'b0}});
    wrapXfer       = advance & accCarry & pendFlag;
    if (deferLoads) begin
      if (wrapXfer) begin
        // A load on the wrap edge bypasses the pending register.
        incActiveNext  = inc_load ? phaseIncCorr : incPending;
        incPendingNext = inc_load ? phaseIncCorr : incPending;
        pendFlagNext   = 1'b0;
        incAppliedNext = 1'b1;
      end else if (inc_load) begin
        // Later loads before the wrap overwrite the pending word.
        incPendingNext = phaseIncCorr;
        pendFlagNext   = 1'b1;
      end else begin
        incPendingNext = incPending;
      end
    end else if (inc_load) begin
      incActiveNext  = phaseIncCorr;
      pendFlagNext   = 1'b0;
      incAppliedNext = 1'b1;
    end else begin
      incActiveNext = incActive;
    end
  end

  // State and registered outputs: reset, clear, enabled advance, or hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc         <= {ACC_W{1'b0}};
      incActive   <= {ACC_W{1'b0}};
      incPending  <= {ACC_W{1'b0}};
      offsetReg   <= {ACC_W{1'b0}};
      pendFlag    <= 1'b0;
      phaseI      <= {OUT_W{1'b0}};
      phaseQ      <= {OUT_W{1'b0}};
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
      inc_applied <= 1'b0;
    end else begin
      incActive   <= incActiveNext;
      incPending  <= incPendingNext;
      pendFlag    <= pendFlagNext;
      inc_applied <= incAppliedNext;
      if (offset_load) begin
        offsetReg <= phase_offset;
      end
      if (phase_clr) begin
        // Re-synchronise: zero the phase, outputs keep their last value.
        acc         <= {ACC_W{1'b0}};
        wrap        <= 1'b0;
        phase_valid <= 1'b0;
      end else if (enable) begin
        phaseI      <= phaseINext;
        phaseQ      <= phaseQNext;
        acc         <= accSum[ACC_W-1:0];
        wrap        <= accCarry;
        phase_valid <= 1'b1;
      end else begin
        wrap        <= 1'b0;
        phase_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/nco_phase_accumulator.md
Name: nco_phase_accumulator

Overview:
- Phase accumulator stage of the NCO, directly downstream of the phase-increment corrector.
- Integrates the corrected 32-bit tuning word every enabled clock.
- Emits truncated in-phase and quadrature (+90°) phase words to the sine/cosine lookup that drives the I/Q demodulator mixers.
- Supports phase-continuous tuning-word updates, a programmable phase offset, and phase clear for channel re-synchronisation.

Parameters:
ACC_W, 32, accumulator and tuning-word width
OUT_W, 12, width of truncated phase outputs (top OUT_W bits of the sum)
UPDATE_ON_WRAP, 1, 1 = loaded tuning word takes effect at the next accumulator wrap; 0 = takes effect on the edge after load

Ports:
CLK  in  1  system clock, all logic rising-edge
RST  in  1  synchronous reset, active-high
enable  in  1  advance accumulator and output stage when high
phaseIncCorr  in  ACC_W  corrected tuning word from phase corrector
inc_load  in  1  single-cycle strobe: capture phaseIncCorr
phase_offset  in  ACC_W  phase offset added to accumulator before truncation
offset_load  in  1  single-cycle strobe: capture phase_offset
phase_clr  in  1  synchronous accumulator clear
phaseI  out  OUT_W  in-phase phase word
phaseQ  out  OUT_W  quadrature phase word = phaseI + 2^(OUT_W-2) mod 2^OUT_W
phase_valid  out  1  high for the cycle after each enabled edge
wrap  out  1  one-cycle pulse: accumulator overflowed on the previous edge
inc_applied  out  1  one-cycle pulse: active tuning word changed on the previous edge

Behaviour:
- Reset (RST high at edge): acc=0, inc_active=0, inc_pending=0, pend_flag=0, offset_reg=0. phaseI, phaseQ, phase_valid, wrap and inc_applied all 0. RST overrides every other input.
- Enabled edge (enable=1, phase_clr=0):
  - phaseI <= top OUT_W bits of (acc + offset_reg) mod 2^ACC_W, using the pre-add acc value.
  - phaseQ <= phaseI_next + 2^(OUT_W-2), wrapping mod 2^OUT_W.
  - acc <= (acc + inc_active) mod 2^ACC_W.
  - wrap <= carry out of acc + inc_active.
  - phase_valid <= 1.
  - Latency: acc to output 1 cycle.
- Disabled edge: acc, phaseI and phaseQ hold. phase_valid <= 0, wrap <= 0. Loads are still captured.
- phase_clr=1: acc <= 0, wrap <= 0, phase_valid <= 0, outputs hold. Priority over enable. Pending tuning word is retained.
- offset_load: offset_reg <= phase_offset. Used from the next edge's output computation.
- inc_load with UPDATE_ON_WRAP=0:
  - inc_active <= phaseIncCorr and inc_applied <= 1.
  - The new word is used from the following edge.
- inc_load with UPDATE_ON_WRAP=1:
  - inc_pending <= phaseIncCorr and pend_flag <= 1.
  - A second load before the wrap overwrites inc_pending; the last value wins.
- Wrap transfer (UPDATE_ON_WRAP=1):
  - On an enabled edge with carry=1 and pend_flag=1: inc_active <= inc_pending, pend_flag <= 0, inc_applied <= 1.
  - If inc_load coincides with that edge, phaseIncCorr bypasses inc_pending and goes straight into inc_active.
- Defaults: inc_applied is 0 on every edge not listed above. No wrap pulse is ever generated by phase_clr or reset.
- inc_active=0: accumulator holds its value while enabled; phase_valid still pulses.
- All arithmetic is unsigned modulo 2^ACC_W. Truncation takes no rounding and no dither.

Test Plan:
- Wrap timing: RST, then inc_load with 858993459 (UPDATE_ON_WRAP=0), then enable held high.
  - phaseI = 0, 819, 1638, 2457, 3276, 4095, then 819 (acc = 858993458).
  - phaseQ = 1024, 1843, 2662, 3481, 204, 1023, 1843.
  - wrap pulses exactly once, on the 6th enabled edge's output cycle.
- Deferred update (UPDATE_ON_WRAP=1): running at 858993459, load 429496729 mid-cycle.
  - inc_applied pulses only coincident with wrap.
  - Subsequent phaseI steps are 409 or 410.
  - No step size other than 819/820 appears before the wrap.
- Overwrite and bypass (UPDATE_ON_WRAP=1):
  - Two loads (100, then 200) before a wrap: 200 becomes active.
  - A load coinciding with the wrap edge becomes active on that edge.
- Offset: offset_load with 0x40000000 while acc=0.
  - phaseI goes 0 -> 1024 on the next output, and phaseQ = 2048.
  - acc is unaffected.
- Clear and enable gating:
  - phase_clr mid-run: next enabled output phaseI = top bits of offset_reg, and no wrap pulse.
  - enable low for 3 cycles: phaseI holds, phase_valid=0, acc resumes without skipping.
- Reset mid-run with a pending word:
  - All outputs read 0 on the next cycle.
  - pend_flag is cleared: no inc_applied at the following wrap.
